// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg: shared FSM state type and source-count limit for the MAC TX packet arbiter
package eth_tx_arb_pkg;
  typedef enum logic {IDLE, XFER} arb_state_t;
  localparam int NUM_SRC_MAX = 8;
endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// eth_tx_arb_rr_pick: combinational round-robin picker (req_i/ptr_i in; idx_o = first request at or after ptr_i with wrap, vld_o = any request)
module eth_tx_arb_rr_pick
  import eth_tx_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  logic [N-1:0] rot;
  logic [IW:0]  sum;
  always_comb begin
    rot = N'({req_i, req_i} >> ptr_i);
    sum = '0;
    for (int j = N-1; j >= 0; j--) sum = rot[j] ? {1'b0, ptr_i} + (IW+1)'(j) : sum;
    idx_o = sum >= (IW+1)'(N) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    vld_o = |req_i;
  end
endmodule

// File: rtl/eth_tx_pkt_arbiter.sv
// eth_tx_pkt_arbiter: frame-granular arbiter of NUM_SRC AXIS sources (s_*) onto one MAC TX FIFO (tx_axis_fifo_*), with grant_idx/busy status and per-source SrcPkg_Cnt cleared by CntClr; define ETH_TX_ARB_PRIO_EN to give source 0 strict priority
module eth_tx_pkt_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W = 64,
  parameter int CNT_W = 32,
  localparam int GW = $clog2(NUM_SRC)
) (
  input  logic                              tx_axis_fifo_aclk,
  input  logic                              tx_axis_aresetn,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]    s_tdata,
  input  logic [NUM_SRC-1:0][DATA_W/8-1:0]  s_tkeep,
  input  logic [NUM_SRC-1:0]                s_tvalid,
  input  logic [NUM_SRC-1:0]                s_tlast,
  output logic [NUM_SRC-1:0]                s_tready,
  output logic [DATA_W-1:0]                 tx_axis_fifo_tdata,
  output logic [DATA_W/8-1:0]               tx_axis_fifo_tkeep,
  output logic                              tx_axis_fifo_tvalid,
  output logic                              tx_axis_fifo_tlast,
  input  logic                              tx_axis_fifo_tready,
  output logic [GW-1:0]                     grant_idx,
  output logic                              busy,
  input  logic                              CntClr,
  output logic [NUM_SRC-1:0][CNT_W-1:0]     SrcPkg_Cnt
);
  arb_state_t                  state_q;
  logic [GW-1:0]               grant_q, rr_q, rr_d, rr_idx, pick_idx;
  logic [NUM_SRC-1:0]          req;
  logic                        rr_vld, pick_vld, xfer, done;
  logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q;
`ifdef ETH_TX_ARB_PRIO_EN
  assign req      = s_tvalid & ~NUM_SRC'(1);
  assign pick_idx = s_tvalid[0] ? '0 : rr_idx;
  assign pick_vld = s_tvalid[0] | rr_vld;
`else
  assign req      = s_tvalid;
  assign pick_idx = rr_idx;
  assign pick_vld = rr_vld;
`endif
  eth_tx_arb_rr_pick #(.N(NUM_SRC)) u_pick (
    .req_i (req),
    .ptr_i (rr_q),
    .idx_o (rr_idx),
    .vld_o (rr_vld)
  );
  assign xfer                = state_q == XFER;
  assign tx_axis_fifo_tdata  = s_tdata[grant_q];
  assign tx_axis_fifo_tkeep  = s_tkeep[grant_q];
  assign tx_axis_fifo_tlast  = s_tlast[grant_q];
  assign tx_axis_fifo_tvalid = xfer & s_tvalid[grant_q];
  assign s_tready            = xfer ? NUM_SRC'(tx_axis_fifo_tready) << grant_q : '0;
  assign done                = tx_axis_fifo_tvalid & tx_axis_fifo_tready & tx_axis_fifo_tlast;
  assign rr_d                = grant_q == GW'(NUM_SRC-1) ? '0 : grant_q + 1'b1;
  assign grant_idx           = grant_q;
  assign busy                = xfer;
  assign SrcPkg_Cnt          = cnt_q;
  always_ff @(posedge tx_axis_fifo_aclk) begin
    if (!tx_axis_aresetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else if (!xfer) begin
      if (pick_vld) begin
        state_q <= XFER;
        grant_q <= pick_idx;
      end
    end else if (done) begin
      state_q <= IDLE;
      rr_q    <= rr_d;
    end
  end
  always_ff @(posedge tx_axis_fifo_aclk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (!tx_axis_aresetn || CntClr) cnt_q[i] <= '0;
      else if (done && grant_q == GW'(i)) cnt_q[i] <= cnt_q[i] + 1'b1;
  end
endmodule

// File: tb/tb_eth_tx_pkt_arbiter.sv
// tb_eth_tx_pkt_arbiter: directed self-checking bench for the MAC TX packet arbiter
module tb_eth_tx_pkt_arbiter;
  localparam int N = 3;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 4;
  logic clk = 0;
  logic rstn = 0;
  always #5 clk = ~clk;
  logic [N-1:0][DW-1:0] s_tdata;
  logic [N-1:0][KW-1:0] s_tkeep;
  logic [N-1:0] s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic tvalid, tlast, tready;
  logic [1:0] grant;
  logic busy, clr;
  logic [N-1:0][CW-1:0] cnt;
  int nvec = 0;
  int nerr = 0;
  int nfr[N], flen[N], beat[N], fno[N];
  int q_src[$];
  logic [DW-1:0] q_data[$];
  logic q_last[$];
  eth_tx_pkt_arbiter #(.NUM_SRC(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .tx_axis_fifo_aclk   (clk),
    .tx_axis_aresetn     (rstn),
    .s_tdata             (s_tdata),
    .s_tkeep             (s_tkeep),
    .s_tvalid            (s_tvalid),
    .s_tlast             (s_tlast),
    .s_tready            (s_tready),
    .tx_axis_fifo_tdata  (tdata),
    .tx_axis_fifo_tkeep  (tkeep),
    .tx_axis_fifo_tvalid (tvalid),
    .tx_axis_fifo_tlast  (tlast),
    .tx_axis_fifo_tready (tready),
    .grant_idx           (grant),
    .busy                (busy),
    .CntClr              (clr),
    .SrcPkg_Cnt          (cnt)
  );
  function automatic logic [DW-1:0] pat(int s, int f, int b);
    return DW'(32'hA000_0000 | (s << 16) | (f << 8) | b);
  endfunction
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = nfr[i] > 0;
      s_tdata[i]  = pat(i, fno[i], beat[i]);
      s_tkeep[i]  = beat[i] == flen[i]-1 ? 8'h0F : 8'hFF;
      s_tlast[i]  = beat[i] == flen[i]-1;
    end
    #1;
  endtask
  task automatic cyc();
    logic [N-1:0] hs;
    hs = s_tvalid & s_tready;
    if (tvalid && tready) begin
      q_src.push_back(int'(grant));
      q_data.push_back(tdata);
      q_last.push_back(tlast);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        if (beat[i] == flen[i]-1) begin
          beat[i] = 0;
          fno[i]++;
          nfr[i]--;
        end else beat[i]++;
      end
    drive();
    #3;
  endtask
  task automatic qclr();
    q_src.delete();
    q_data.delete();
    q_last.delete();
  endtask
  task automatic test_reset();
    nfr[1] = 1; flen[1] = 2;
    drive();
    cyc(); cyc();
    nvec++; if (tvalid !== 1'b0) begin nerr++; $display("FAIL rst_tvalid got=%b exp=0", tvalid); end
    nvec++; if (s_tready !== 3'b000) begin nerr++; $display("FAIL rst_s_tready got=%b exp=000", s_tready); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got=%b exp=0", busy); end
    nvec++; if (grant !== 2'd0) begin nerr++; $display("FAIL rst_grant got=%0d exp=0", grant); end
    nvec++; if (cnt !== '0) begin nerr++; $display("FAIL rst_cnt got=%h exp=0", cnt); end
    nfr[1] = 0; beat[1] = 0;
    drive();
    rstn = 1;
    cyc();
    nvec++; if (busy !== 1'b0 || tvalid !== 1'b0) begin nerr++; $display("FAIL rst_idle busy=%b tvalid=%b exp=0/0", busy, tvalid); end
  endtask
  task automatic test_contention();
    int c = 0;
    int seen[N] = '{default: 0};
`ifdef ETH_TX_ARB_PRIO_EN
    int ord[4] = '{0, 0, 1, 1};
`else
    int ord[4] = '{0, 1, 0, 1};
`endif
    qclr();
    flen[0] = 3; flen[1] = 3; nfr[0] = 2; nfr[1] = 2;
    drive();
    while (q_src.size() < 12 && c < 40) begin cyc(); c++; end
    nvec++; if (c != 16) begin nerr++; $display("FAIL cont_cycles got=%0d exp=16", c); end
    nvec++;
    if (q_src.size() != 12) begin nerr++; $display("FAIL cont_beats got=%0d exp=12", q_src.size()); end
    else
      for (int j = 0; j < 4; j++) begin
        for (int b = 0; b < 3; b++) begin
          nvec++;
          if (q_src[j*3+b] !== ord[j] || q_data[j*3+b] !== pat(ord[j], seen[ord[j]], b) || q_last[j*3+b] !== (b == 2)) begin
            nerr++;
            $display("FAIL cont_beat%0d got src=%0d data=%h last=%b exp src=%0d data=%h last=%b", j*3+b,
                     q_src[j*3+b], q_data[j*3+b], q_last[j*3+b], ord[j], pat(ord[j], seen[ord[j]], b), b == 2);
          end
        end
        seen[ord[j]]++;
      end
    nvec++; if (cnt[0] !== 4'd2 || cnt[1] !== 4'd2) begin nerr++; $display("FAIL cont_cnt got=%0d/%0d exp=2/2", cnt[0], cnt[1]); end
  endtask
  task automatic test_single();
    int f = fno[0];
    nfr[0] = 1; flen[0] = 4;
    drive();
    nvec++; if (tvalid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL single_arb tvalid=%b busy=%b exp=0/0", tvalid, busy); end
    cyc();
    for (int b = 0; b < 4; b++) begin
      nvec++;
      if (tvalid !== 1'b1 || busy !== 1'b1 || grant !== 2'd0 || tdata !== pat(0, f, b) || tlast !== (b == 3) ||
          tkeep !== (b == 3 ? 8'h0F : 8'hFF) || s_tready !== 3'b001) begin
        nerr++;
        $display("FAIL single_beat%0d got v=%b busy=%b g=%0d d=%h l=%b k=%h rdy=%b exp v=1 busy=1 g=0 d=%h l=%b rdy=001",
                 b, tvalid, busy, grant, tdata, tlast, tkeep, s_tready, pat(0, f, b), b == 3);
      end
      cyc();
    end
    nvec++; if (busy !== 1'b0 || tvalid !== 1'b0) begin nerr++; $display("FAIL single_end busy=%b tvalid=%b exp=0/0", busy, tvalid); end
    nvec++; if (cnt[0] !== 4'd3) begin nerr++; $display("FAIL single_cnt got=%0d exp=3", cnt[0]); end
  endtask
  task automatic test_backpressure();
    int c;
    int f = fno[1];
    qclr();
    tready = 1; nfr[1] = 1; flen[1] = 8;
    drive();
    cyc();
    nfr[0] = 1; flen[0] = 2;
    drive();
    for (c = 0; c < 30 && q_data.size() < 8; c++) begin
      tready = (c % 2 == 0);
      #1;
      nvec++;
      if (grant !== 2'd1 || tvalid !== 1'b1 || s_tready !== {1'b0, tready, 1'b0} || tdata !== pat(1, f, q_data.size())) begin
        nerr++;
        $display("FAIL bp_cycle%0d got g=%0d v=%b rdy=%b d=%h exp g=1 v=1 rdy=0%b0 d=%h", c, grant, tvalid, s_tready, tdata,
                 tready, pat(1, f, q_data.size()));
      end
      cyc();
    end
    nvec++; if (c != 15) begin nerr++; $display("FAIL bp_cycles got=%0d exp=15", c); end
    nvec++;
    if (q_data.size() != 8) begin nerr++; $display("FAIL bp_beats got=%0d exp=8", q_data.size()); end
    else
      for (int k = 0; k < 8; k++) begin
        nvec++;
        if (q_src[k] !== 1 || q_data[k] !== pat(1, f, k) || q_last[k] !== (k == 7)) begin
          nerr++;
          $display("FAIL bp_beat%0d got src=%0d d=%h l=%b exp src=1 d=%h l=%b", k, q_src[k], q_data[k], q_last[k], pat(1, f, k), k == 7);
        end
      end
    tready = 1;
    #1;
    nvec++; if (busy !== 1'b0 || tvalid !== 1'b0 || s_tready !== 3'b000) begin nerr++; $display("FAIL bp_gap busy=%b v=%b rdy=%b exp 0/0/000", busy, tvalid, s_tready); end
    cyc();
    nvec++; if (grant !== 2'd0 || busy !== 1'b1) begin nerr++; $display("FAIL bp_next got g=%0d busy=%b exp g=0 busy=1", grant, busy); end
    cyc(); cyc();
    nvec++; if (cnt[0] !== 4'd4 || cnt[1] !== 4'd3 || busy !== 1'b0) begin nerr++; $display("FAIL bp_cnt got=%0d/%0d busy=%b exp=4/3 busy=0", cnt[0], cnt[1], busy); end
  endtask
  task automatic test_cnt_clr();
    nfr[0] = 1; flen[0] = 1;
    drive();
    cyc();
    nvec++; if (busy !== 1'b1 || tvalid !== 1'b1 || tlast !== 1'b1) begin nerr++; $display("FAIL one_beat busy=%b v=%b l=%b exp 1/1/1", busy, tvalid, tlast); end
    cyc();
    nvec++; if (busy !== 1'b0 || cnt[0] !== 4'd5) begin nerr++; $display("FAIL one_beat_end busy=%b cnt=%0d exp busy=0 cnt=5", busy, cnt[0]); end
    nfr[0] = 1; flen[0] = 2;
    drive();
    cyc(); cyc();
    clr = 1;
    #1;
    nvec++; if (tvalid !== 1'b1 || tlast !== 1'b1 || s_tready !== 3'b001) begin nerr++; $display("FAIL clr_last v=%b l=%b rdy=%b exp 1/1/001", tvalid, tlast, s_tready); end
    cyc();
    clr = 0;
    #1;
    nvec++; if (cnt !== '0) begin nerr++; $display("FAIL clr_wins got=%h exp=0", cnt); end
    nfr[0] = 1; flen[0] = 1;
    drive();
    cyc(); cyc();
    nvec++; if (cnt[0] !== 4'd1) begin nerr++; $display("FAIL clr_recount got=%0d exp=1", cnt[0]); end
  endtask
  task automatic test_wrap();
    int c = 0;
    qclr();
    nfr[2] = 15; flen[2] = 1;
    drive();
    while (q_src.size() < 15 && c < 60) begin cyc(); c++; end
    nvec++; if (cnt[2] !== 4'd15) begin nerr++; $display("FAIL wrap_max got=%0d exp=15", cnt[2]); end
    nfr[2] = 1;
    drive();
    cyc(); cyc();
    nvec++; if (cnt[2] !== 4'd0) begin nerr++; $display("FAIL wrap_zero got=%0d exp=0", cnt[2]); end
  endtask
  task automatic test_mid_reset();
    int f = fno[2];
    nfr[2] = 1; flen[2] = 6;
    drive();
    cyc(); cyc(); cyc();
    nvec++; if (grant !== 2'd2 || tdata !== pat(2, f, 2)) begin nerr++; $display("FAIL mr_beat2 got g=%0d d=%h exp g=2 d=%h", grant, tdata, pat(2, f, 2)); end
    rstn = 0;
    cyc();
    nvec++;
    if (tvalid !== 1'b0 || s_tready !== 3'b000 || grant !== 2'd0 || busy !== 1'b0 || cnt !== '0) begin
      nerr++;
      $display("FAIL mr_reset got v=%b rdy=%b g=%0d busy=%b cnt=%h exp 0/000/0/0/0", tvalid, s_tready, grant, busy, cnt);
    end
    beat[2] = 0; fno[2] = f + 1; flen[2] = 2; nfr[2] = 1;
    rstn = 1;
    drive();
    cyc();
    nvec++; if (busy !== 1'b1 || grant !== 2'd2 || tdata !== pat(2, f + 1, 0)) begin nerr++; $display("FAIL mr_regrant got busy=%b g=%0d d=%h exp 1/2/%h", busy, grant, tdata, pat(2, f + 1, 0)); end
    cyc(); cyc();
    nvec++; if (cnt[2] !== 4'd1 || busy !== 1'b0) begin nerr++; $display("FAIL mr_cnt got=%0d busy=%b exp=1/0", cnt[2], busy); end
  endtask
  task automatic test_prio();
    int c = 0;
`ifdef ETH_TX_ARB_PRIO_EN
    int ord[9] = '{0, 0, 0, 1, 2, 1, 2, 1, 2};
`else
    int ord[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
    qclr();
    for (int i = 0; i < N; i++) begin nfr[i] = 3; flen[i] = 1; beat[i] = 0; end
    drive();
    while (q_src.size() < 9 && c < 40) begin cyc(); c++; end
    nvec++; if (c != 18) begin nerr++; $display("FAIL prio_cycles got=%0d exp=18", c); end
    nvec++;
    if (q_src.size() != 9) begin nerr++; $display("FAIL prio_frames got=%0d exp=9", q_src.size()); end
    else
      for (int j = 0; j < 9; j++) begin
        nvec++;
        if (q_src[j] !== ord[j] || q_last[j] !== 1'b1) begin nerr++; $display("FAIL prio_grant%0d got src=%0d l=%b exp src=%0d l=1", j, q_src[j], q_last[j], ord[j]); end
      end
  endtask
  initial begin
    clr = 0;
    tready = 1;
    for (int i = 0; i < N; i++) begin nfr[i] = 0; flen[i] = 1; beat[i] = 0; fno[i] = 0; end
    drive();
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_cnt_clr();
    test_wrap();
    test_mid_reset();
    test_prio();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
